// File: rtl/scan_pkg.sv
// Shared definitions for writers into the laser FIFO: word magics, the trailer
// flag layout, the packer state encoding and the frame reservation size.
// Optional timestamp word: SCAN_PACK_TIMESTAMP_EN.
package scan_pkg;

  localparam logic [7:0] HDR_MAGIC  = 8'hA5;
  localparam logic [7:0] TRL_MAGIC  = 8'h5A;
  localparam int         FLAG_SHORT = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TSTAMP = 3'd1,
    PACK   = 3'd2,
    TRAIL  = 3'd3,
    SKIP   = 3'd4
  } state_t;

  // Words a whole frame occupies: header, samples, trailer (+ timestamp word).
  function automatic int reserve_words(input int points);
`ifdef SCAN_PACK_TIMESTAMP_EN
    return points + 3;
`else
    return points + 2;
`endif
  endfunction

endpackage

// File: rtl/scan_space_check.sv
// Admission test for a writer into the laser FIFO: a frame of RESERVE words is
// admitted only if it fits entirely while keeping one slot free, and never
// while the FIFO reports full. The sum is formed two bits wider than usedw so
// it cannot wrap.
module scan_space_check
  import scan_pkg::*;
#(
  parameter int FIFO_DEPTH = 2048,
  parameter int USEDW_W    = 11,
  parameter int RESERVE    = 542
) (
  input  logic [USEDW_W-1:0] i_fifo_usedw,
  input  logic               i_fifo_full,
  output logic               o_space_ok
);

  localparam int            CW        = USEDW_W + 2;
  localparam logic [CW-1:0] C_RESERVE = CW'(RESERVE);
  localparam logic [CW-1:0] C_LIMIT   = CW'(FIFO_DEPTH - 1);

  logic [CW-1:0] w_need;

  assign w_need     = {2'b00, i_fifo_usedw} + C_RESERVE;
  assign o_space_ok = !i_fifo_full && (w_need <= C_LIMIT);

endmodule

// File: rtl/scan_frame_packer.sv
// Packs the per-angle samples of one scan revolution into framed 32-bit words
// (header, data..., trailer) for the laser FIFO. A frame is admitted only when
// the whole frame fits, so the reader never sees a partial frame except after
// reset. Optional timestamp word after the header: SCAN_PACK_TIMESTAMP_EN.
module scan_frame_packer
  import scan_pkg::*;
#(
  parameter int POINTS     = 540,
  parameter int FIFO_DEPTH = 2048,
  parameter int USEDW_W    = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_enable,
  input  logic               frame_start,
  input  logic               sample_valid,
  input  logic [15:0]        sample_dist,
  input  logic [15:0]        sample_peak,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic               fifo_full,
  output logic               fifo_wrreq,
  output logic [31:0]        fifo_wrdata,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        drop_cnt,
  output logic               busy
);

  localparam int               RESERVE = reserve_words(POINTS);
  localparam int               CNT_W   = $clog2(POINTS + 1);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(POINTS - 1);

  state_t           r_state;
  logic             r_pending;
  logic             r_short;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_csum;
  logic [15:0]      r_frame_cnt;
  logic [15:0]      r_drop_cnt;
  logic             r_wrreq;
  logic [31:0]      r_wrdata;

  logic             w_space_ok;
  logic             w_start;
  logic [7:0]       w_flags;
  logic [31:0]      w_sample_word;

  assign w_sample_word = {sample_dist, sample_peak};

  scan_space_check #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .USEDW_W    (USEDW_W),
    .RESERVE    (RESERVE)
  ) u_space_check (
    .i_fifo_usedw (fifo_usedw),
    .i_fifo_full  (fifo_full),
    .o_space_ok   (w_space_ok)
  );

`ifdef SCAN_PACK_TIMESTAMP_EN
  logic [6:0]  r_prescale;
  logic [31:0] r_us_cnt;
  logic [31:0] r_ts;

  // Free-running microsecond counter: one tick every 100 clocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prescale <= 7'd0;
      r_us_cnt   <= 32'd0;
    end else if (r_prescale == 7'd99) begin
      r_prescale <= 7'd0;
      r_us_cnt   <= r_us_cnt + 32'd1;
    end else begin
      r_prescale <= r_prescale + 7'd1;
    end
  end
`endif

  // A new frame begins from IDLE (fresh pulse or one held over from a trailer)
  // or from SKIP; only while packing is enabled.
  always_comb begin
    w_start = 1'b0;
    case (r_state)
      IDLE:    w_start = (frame_start || r_pending) && cfg_enable;
      SKIP:    w_start = frame_start && cfg_enable;
      default: w_start = 1'b0;
    endcase
  end

  // Trailer flag byte.
  always_comb begin
    w_flags             = 8'h00;
    w_flags[FLAG_SHORT] = r_short;
  end

  // Frame sequencer; every FIFO write is registered here, one cycle after its cause.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_short     <= 1'b0;
      r_cnt       <= '0;
      r_csum      <= 32'd0;
      r_frame_cnt <= 16'd0;
      r_drop_cnt  <= 16'd0;
      r_wrreq     <= 1'b0;
      r_wrdata    <= 32'd0;
`ifdef SCAN_PACK_TIMESTAMP_EN
      r_ts        <= 32'd0;
`endif
    end else begin
      r_wrreq <= 1'b0;
      if (w_start) begin
        // A sample coincident with the start pulse is deliberately discarded.
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_pending   <= 1'b0;
        if (w_space_ok) begin
          r_wrreq  <= 1'b1;
          r_wrdata <= {HDR_MAGIC, 8'h00, r_frame_cnt};
          r_cnt    <= '0;
          r_csum   <= 32'd0;
          r_short  <= 1'b0;
`ifdef SCAN_PACK_TIMESTAMP_EN
          r_ts     <= r_us_cnt;
          r_state  <= TSTAMP;
`else
          r_state  <= PACK;
`endif
        end else begin
          if (r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
          end
          r_state <= SKIP;
        end
      end else begin
        case (r_state)
          IDLE: begin
            // A held-over start is forgotten once packing has been disabled.
            r_pending <= 1'b0;
          end
`ifdef SCAN_PACK_TIMESTAMP_EN
          TSTAMP: begin
            r_wrreq  <= 1'b1;
            r_wrdata <= r_ts;
            if (frame_start) begin
              r_short   <= 1'b1;
              r_pending <= 1'b1;
              r_state   <= TRAIL;
            end else begin
              r_state <= PACK;
            end
          end
`endif
          PACK: begin
            if (frame_start) begin
              r_short   <= 1'b1;
              r_pending <= 1'b1;
              r_state   <= TRAIL;
            end else if (sample_valid) begin
              r_wrreq  <= 1'b1;
              r_wrdata <= w_sample_word;
              r_csum   <= r_csum ^ w_sample_word;
              r_cnt    <= r_cnt + 1'b1;
              if (r_cnt == C_LAST) begin
                r_state <= TRAIL;
              end
            end
          end
          TRAIL: begin
            // Header of a pending frame follows in the next cycle from IDLE.
            r_wrreq  <= 1'b1;
            r_wrdata <= {TRL_MAGIC, w_flags, r_csum[31:16] ^ r_csum[15:0]};
            if (frame_start) begin
              r_pending <= 1'b1;
            end
            r_state <= IDLE;
          end
          SKIP: begin
            if (!cfg_enable) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign fifo_wrreq  = r_wrreq;
  assign fifo_wrdata = r_wrdata;
  assign frame_cnt   = r_frame_cnt;
  assign drop_cnt    = r_drop_cnt;
  assign busy        = (r_state != IDLE);

endmodule
